// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port between the MEM-stage access sequencer and the memory.
// The controller drives the request side and the memory returns ack and read data.
interface dmem_access_ctrl_if;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: runs one req/ack access per EX/MEM entry, stalls
// the pipeline while it is outstanding, and returns lane-extracted, extended load data.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                flush,
  input  logic                i_MemRead,
  input  logic                i_MemWrite,
  input  logic [2:0]          i_DMType,
  input  logic [31:0]         i_addr,
  input  logic [31:0]         i_Store_Data,
  dmem_access_ctrl_if.master  mem,
  output logic                o_stall,
  output logic [31:0]         o_load_data,
  output logic                o_done,
  output logic                o_misaligned,
  output logic                o_bus_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  function automatic logic [1:0] size_of(input logic [2:0] dm);
    case (dm)
      3'b001, 3'b010: size_of = SZ_HALF;
      3'b011, 3'b100: size_of = SZ_BYTE;
      default:        size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: is_aligned = (off[0] == 1'b0);
      SZ_BYTE: is_aligned = 1'b1;
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
      SZ_BYTE: byte_en = 4'b0001 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_HALF: lane_data = {2{d[15:0]}};
      SZ_BYTE: lane_data = {4{d[7:0]}};
      default: lane_data = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend according to the load type.
  function automatic logic [31:0] extract(input logic [2:0] dm, input logic [1:0] off,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (dm)
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extract = {16'h0000, sh[15:0]};
      3'b011:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract = {24'h000000, sh[7:0]};
      default: extract = rdata;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic [2:0]  dm_r;
  logic [1:0]  off_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] load_data_r;
  logic        done_r;
  logic        bus_err_r;

  logic [1:0]  sz_s;
  logic        cand_s;
  logic        start_s;
  logic        misaligned_s;
  logic        stall_s;

  // Start / reject decision in IDLE and the combinational pipeline stall.
  always_comb begin
    sz_s         = size_of(i_DMType);
    cand_s       = ~reset & (state_r == ST_IDLE) & i_valid & ~flush & (i_MemRead | i_MemWrite);
    start_s      = cand_s & is_aligned(sz_s, i_addr[1:0]);
    misaligned_s = cand_s & ~is_aligned(sz_s, i_addr[1:0]);
    case (state_r)
      ST_IDLE:   stall_s = start_s;
      ST_ACCESS: stall_s = 1'b1;
      default:   stall_s = 1'b0;
    endcase
  end

  // Access FSM, request registers, timeout counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      dm_r        <= 3'd0;
      off_r       <= 2'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      load_data_r <= 32'd0;
      done_r      <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
          if (start_s) begin
            state_r     <= ST_ACCESS;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b1;
            mem_we_r    <= i_MemWrite;
            mem_addr_r  <= {i_addr[31:2], 2'b00};
            mem_be_r    <= byte_en(sz_s, i_addr[1:0]);
            mem_wdata_r <= lane_data(sz_s, i_Store_Data);
            dm_r        <= i_DMType;
            off_r       <= i_addr[1:0];
          end
        end
        ST_ACCESS: begin
          if (mem.i_mem_ack) begin
            state_r   <= ST_DONE;
            mem_req_r <= 1'b0;
            done_r    <= 1'b1;
            if (!mem_we_r) begin
              load_data_r <= extract(dm_r, off_r, mem.i_mem_rdata);
            end
          end else if (cnt_r >= TO_LAST) begin
            state_r     <= ST_DONE;
            mem_req_r   <= 1'b0;
            done_r      <= 1'b1;
            bus_err_r   <= 1'b1;
            load_data_r <= 32'd0;
          end else if (cnt_r != 8'hFF) begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          done_r    <= 1'b0;
          bus_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem.o_mem_req   = mem_req_r;
  assign mem.o_mem_we    = mem_we_r;
  assign mem.o_mem_addr  = mem_addr_r;
  assign mem.o_mem_be    = mem_be_r;
  assign mem.o_mem_wdata = mem_wdata_r;
  assign o_stall         = stall_s;
  assign o_misaligned    = misaligned_s;
  assign o_load_data     = load_data_r;
  assign o_done          = done_r;
  assign o_bus_err       = bus_err_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares on every done or misaligned pulse.
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        i_valid, flush, i_MemRead, i_MemWrite;
  logic [2:0]  i_DMType;
  logic [31:0] i_addr, i_Store_Data;
  logic        o_stall, o_done, o_misaligned, o_bus_err;
  logic [31:0] o_load_data;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .flush(flush),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_DMType(i_DMType),
    .i_addr(i_addr), .i_Store_Data(i_Store_Data), .mem(bus.master),
    .o_stall(o_stall), .o_load_data(o_load_data), .o_done(o_done),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  typedef struct {
    bit          mis;
    logic [31:0] ld;
    bit          berr;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    int          stall;
    int          req;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  bit seen = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit mis, input logic [31:0] ld, input bit berr,
                              input logic [31:0] addr, input logic [3:0] be, input bit we,
                              input logic [31:0] wdata, input int stall, input int req);
    exp_t e;
    e.mis = mis; e.ld = ld; e.berr = berr; e.addr = addr; e.be = be;
    e.we = we; e.wdata = wdata; e.stall = stall; e.req = req;
    return e;
  endfunction

  // Monitor: accumulate stall/request activity and score each response against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0; req_cnt = 0; seen = 1'b0;
      end else begin
        if (o_stall) stall_cnt++;
        if (bus.o_mem_req) begin
          req_cnt++;
          if (!seen) begin
            cap_addr = bus.o_mem_addr; cap_be = bus.o_mem_be;
            cap_we = bus.o_mem_we; cap_wdata = bus.o_mem_wdata;
            seen = 1'b1;
          end
        end
        if (o_done || o_misaligned) begin
          if (q.size() == 0) begin
            check("unexpected_response", {30'd0, o_done, o_misaligned}, 32'd0);
          end else begin
            e = q.pop_front();
            check("kind_misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
            if (e.mis) begin
              check("mis_no_req", {31'd0, bus.o_mem_req}, 32'd0);
              check("mis_no_stall", stall_cnt, 32'd0);
              check("mis_no_done", {31'd0, o_done}, 32'd0);
            end else begin
              check("load_data", o_load_data, e.ld);
              check("bus_err", {31'd0, o_bus_err}, {31'd0, e.berr});
              check("mem_addr", cap_addr, e.addr);
              check("mem_be", {28'd0, cap_be}, {28'd0, e.be});
              check("mem_we", {31'd0, cap_we}, {31'd0, e.we});
              if (e.we) check("mem_wdata", cap_wdata, e.wdata);
              check("stall_cycles", stall_cnt, e.stall);
              check("req_cycles", req_cnt, e.req);
            end
          end
          stall_cnt = 0; req_cnt = 0; seen = 1'b0;
        end
      end
    end
  end

  // Present one EX/MEM entry for a single cycle, then answer with ack after k ACCESS cycles (k<0: never).
  task automatic issue(input bit rd, input bit wr, input logic [2:0] dm, input logic [31:0] a,
                       input logic [31:0] sd, input int k, input logic [31:0] rdata);
    @(posedge clk); #1;
    i_valid = 1'b1; i_MemRead = rd; i_MemWrite = wr; i_DMType = dm;
    i_addr = a; i_Store_Data = sd;
    @(posedge clk); #1;
    i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    for (int j = 0; j < TO + 2; j++) begin
      bus.i_mem_ack   = (j == k);
      bus.i_mem_rdata = (j == k) ? rdata : 32'h0;
      @(posedge clk); #1;
      if (j == k) break;
    end
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; flush = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    i_DMType = 3'd0; i_addr = 32'd0; i_Store_Data = 32'd0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'd0;
    #12;
    check("rst_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("rst_we", {31'd0, bus.o_mem_we}, 32'd0);
    check("rst_be", {28'd0, bus.o_mem_be}, 32'd0);
    check("rst_addr", bus.o_mem_addr, 32'd0);
    check("rst_wdata", bus.o_mem_wdata, 32'd0);
    check("rst_load", o_load_data, 32'd0);
    check("rst_flags", {28'd0, o_done, o_bus_err, o_stall, o_misaligned}, 32'd0);
    #10 reset = 1'b0;

    q.push_back(mk(1'b0, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0, 5, 4));
    issue(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    q.push_back(mk(1'b0, 32'hFFFFFF80, 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0, 3, 2));
    issue(1'b1, 1'b0, 3'b011, 32'h103, 32'h0, 1, 32'h80FF0000);
    q.push_back(mk(1'b0, 32'h00000080, 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0, 2, 1));
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000);
    q.push_back(mk(1'b0, 32'h00000080, 1'b0, 32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 2, 1));
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h55555555);
    q.push_back(mk(1'b1, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 0, 0));
    issue(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h77777777);
    q.push_back(mk(1'b1, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 0, 0));
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, -1, 32'h0);
    q.push_back(mk(1'b0, 32'h00000056, 1'b0, 32'h100, 4'b0010, 1'b0, 32'h0, 2, 1));
    issue(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 0, 32'h12345678);
    q.push_back(mk(1'b0, 32'hFFFF8001, 1'b0, 32'h100, 4'b1100, 1'b0, 32'h0, 4, 3));
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80011234);
    q.push_back(mk(1'b0, 32'h00008001, 1'b0, 32'h100, 4'b1100, 1'b0, 32'h0, 2, 1));
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h80011234);
    q.push_back(mk(1'b0, 32'h00008001, 1'b0, 32'h200, 4'b1111, 1'b1, 32'h11223344, 3, 2));
    issue(1'b1, 1'b1, 3'b000, 32'h200, 32'h11223344, 1, 32'h99999999);
    q.push_back(mk(1'b0, 32'h00000000, 1'b1, 32'h300, 4'b1111, 1'b0, 32'h0, TO + 1, TO));
    issue(1'b1, 1'b0, 3'b000, 32'h300, 32'h0, -1, 32'h0);

    // Flushed store in IDLE: nothing may happen.
    @(posedge clk); #1;
    i_valid = 1'b1; flush = 1'b1; i_MemWrite = 1'b1; i_DMType = 3'b000;
    i_addr = 32'h500; i_Store_Data = 32'h01020304;
    @(posedge clk); #1;
    i_valid = 1'b0; flush = 1'b0; i_MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("flush_no_stall", stall_cnt, 32'd0);
    check("flush_no_req", req_cnt, 32'd0);

    // Reset in the middle of an access: request must drop without a clock edge.
    i_valid = 1'b1; i_MemRead = 1'b1; i_DMType = 3'b000; i_addr = 32'h400;
    @(posedge clk); #1;
    i_valid = 1'b0; i_MemRead = 1'b0;
    @(posedge clk); #1;
    check("req_before_reset", {31'd0, bus.o_mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("req_async_drop", {31'd0, bus.o_mem_req}, 32'd0);
    check("stall_in_reset", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    q.push_back(mk(1'b0, 32'hCAFEF00D, 1'b0, 32'h104, 4'b1111, 1'b0, 32'h0, 2, 1));
    issue(1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 0, 32'hCAFEF00D);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    check("pending_responses", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
